// File: rtl/pwm_output_pkg.sv
// Shared sample-path constants and helpers for the PWM output stage.
// Mirrors the SAMPLE_W / midscale definitions used by the interpolator.
package pwm_output_pkg;

  localparam int SAMPLE_W     = 16;
  localparam int CNT_BITS_MIN = 4;
  localparam int CNT_BITS_MAX = 12;

  // Midscale duty for a counter of the given width: half of 2^bits.
  function automatic int midscale(input int bits);
    return 1 << (bits - 1);
  endfunction

  // Signed two's complement to offset binary: flip the sign bit.
  function automatic logic [SAMPLE_W-1:0] offset_binary(input logic signed [SAMPLE_W-1:0] s);
    return {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
  endfunction

endpackage

// File: rtl/pwm_output.sv
// Error-feedback PWM pin driver: one sample per 2^CNT_BITS period, duty shows from the cycle after the load edge.
// No backpressure; sample_tick paces upstream, inputs are only sampled on the load edge (cnt at max).
module pwm_output
  import pwm_output_pkg::*;
#(
  parameter int CNT_BITS = 8
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic signed [SAMPLE_W-1:0] pwm_value,
  input  logic                       mute,
  output logic                       pwm_out,
  output logic                       sample_tick,
  output logic [CNT_BITS:0]          duty_dbg
);

  localparam int ERR_W = SAMPLE_W - CNT_BITS;

  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
  localparam logic [CNT_BITS-1:0] CNT_ZERO = '0;
  localparam logic [CNT_BITS:0]   DUTY_MID = (CNT_BITS+1)'(midscale(CNT_BITS));

  if (CNT_BITS < CNT_BITS_MIN || CNT_BITS > CNT_BITS_MAX) begin : g_bad_cnt_bits
    $error("pwm_output: CNT_BITS must be in 4..12");
  end

  logic [CNT_BITS-1:0] cnt;
  logic [CNT_BITS-1:0] cnt_nxt;
  logic [CNT_BITS:0]   duty;
  logic [CNT_BITS:0]   duty_nxt;
  logic [ERR_W-1:0]    err;
  logic [ERR_W-1:0]    err_nxt;
  logic [SAMPLE_W-1:0] u;
  logic [SAMPLE_W:0]   sum;
  logic                load;
  logic                pwm_nxt;
  logic                tick_nxt;

  // Offset-binary sample plus carried residual; 17 bits so the add never wraps.
  always_comb begin
    u   = offset_binary(pwm_value);
    sum = {1'b0, u} + {{(SAMPLE_W + 1 - ERR_W){1'b0}}, err};
  end

  always_comb begin
    cnt_nxt  = cnt + CNT_ONE;
    load     = (cnt == CNT_MAX);
    duty_nxt = duty;
    err_nxt  = err;
    if (load) begin
      if (mute) begin
        duty_nxt = DUTY_MID;
        err_nxt  = '0;
      end else begin
        duty_nxt = sum[SAMPLE_W:ERR_W];
        err_nxt  = sum[ERR_W-1:0];
      end
    end
  end

  // Compare on next-state values so the pin comes straight off a flop.
  always_comb begin
    pwm_nxt  = ({1'b0, cnt_nxt} < duty_nxt);
    tick_nxt = (cnt_nxt == CNT_ZERO);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt         <= '0;
      duty        <= DUTY_MID;
      err         <= '0;
      pwm_out     <= 1'b0;
      sample_tick <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      duty        <= duty_nxt;
      err         <= err_nxt;
      pwm_out     <= pwm_nxt;
      sample_tick <= tick_nxt;
    end
  end

  assign duty_dbg = duty;

endmodule

// File: tb/tb_pwm_output.sv
// Directed bench for pwm_output at CNT_BITS=8: table of per-period loads plus reset and sampling-window sequences.
module tb_pwm_output;

  logic               Clk = 1'b0;
  logic               Reset;
  logic signed [15:0] pwm_value;
  logic               mute;
  logic               pwm_out;
  logic               sample_tick;
  logic [8:0]         duty_dbg;

  int checks = 0;
  int errors = 0;

  pwm_output #(.CNT_BITS(8)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .pwm_value   (pwm_value),
    .mute        (mute),
    .pwm_out     (pwm_out),
    .sample_tick (sample_tick),
    .duty_dbg    (duty_dbg)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic signed [15:0] val;
    logic               mute;
    int                 exp_duty;
    logic               dither;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Counts cycles until sample_tick, bounded.
  task automatic wait_tick(output int n, output int highs);
    n = 0;
    highs = 0;
    while (!sample_tick && n < 1000) begin
      highs += int'(pwm_out);
      step();
      n++;
    end
  endtask

  // Entered in a cnt=0 cycle; measures one full period and ends in the next cnt=0 cycle.
  task automatic run_period(output int highs, output int d);
    int ticks;
    highs = 0;
    ticks = 0;
    d = int'(duty_dbg);
    for (int i = 0; i < 256; i++) begin
      highs += int'(pwm_out);
      ticks += int'(sample_tick);
      step();
    end
    chk("tick_once_per_period", ticks, 1);
    chk("tick_at_period_start", int'(sample_tick), 1);
  endtask

  vec_t vecs[12];
  int   n, h, d, prev_d, dither_sum;

  initial begin
    vecs[0]  = '{16'sh0000, 1'b0, 128, 1'b0};
    vecs[1]  = '{-16'sd32768, 1'b0, 0, 1'b0};
    vecs[2]  = '{16'sh7FFF, 1'b0, 255, 1'b0};   // err -> 0xFF
    vecs[3]  = '{16'sh7FFF, 1'b0, 256, 1'b0};   // carry, err -> 0xFE
    vecs[4]  = '{16'sd20000, 1'b1, 128, 1'b0};
    vecs[5]  = '{16'sd20000, 1'b0, 206, 1'b0};  // err -> 0x20
    vecs[6]  = '{16'sh0000, 1'b1, 128, 1'b0};
    vecs[7]  = '{16'sh0080, 1'b0, 128, 1'b1};
    vecs[8]  = '{16'sh0080, 1'b0, 129, 1'b1};
    vecs[9]  = '{16'sh0080, 1'b0, 128, 1'b1};
    vecs[10] = '{16'sh0080, 1'b0, 129, 1'b1};
    vecs[11] = '{16'sh7FFF, 1'b1, 128, 1'b0};   // mute beats full scale

    Reset = 1'b1;
    pwm_value = 16'sh0000;
    mute = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_pwm_out", int'(pwm_out), 0);
      chk("rst_tick", int'(sample_tick), 0);
      chk("rst_duty", int'(duty_dbg), 128);
    end
    Reset = 1'b0;
    step();
    wait_tick(n, h);
    chk("first_tick_delay", n, 255);
    chk("first_period_highs", h, 127);

    prev_d = 128;
    dither_sum = 0;
    for (int i = 0; i < 12; i++) begin
      pwm_value = vecs[i].val;
      mute = vecs[i].mute;
      run_period(h, d);
      chk("period_duty", d, prev_d);
      chk("period_highs", h, prev_d);
      if (i > 0 && vecs[i-1].dither) dither_sum += h;
      prev_d = vecs[i].exp_duty;
    end

    // Final table entry loads 128 and clears err; -1 gives u=0x7FFF -> duty 127, err 0xFF.
    pwm_value = -16'sd1;
    mute = 1'b0;
    run_period(h, d);
    chk("period_duty", d, prev_d);
    chk("period_highs", h, prev_d);
    chk("dither_total_4_periods", dither_sum, 514);

    // Change the sample 10 cycles into the period: current duty (127) must hold.
    h = 0;
    d = int'(duty_dbg);
    chk("win_start_duty", d, 127);
    for (int i = 0; i < 256; i++) begin
      if (i == 10) pwm_value = 16'sh4000;
      if (i == 255) chk("win_duty_held", int'(duty_dbg), 127);
      h += int'(pwm_out);
      step();
    end
    chk("win_highs", h, 127);
    run_period(h, d);
    chk("win_new_duty", d, 192);   // 0xC000 + 0xFF -> 192
    chk("win_new_highs", h, 192);

    // Reset mid-period abandons the period.
    for (int i = 0; i < 37; i++) step();
    Reset = 1'b1;
    step();
    chk("midrst_pwm_out", int'(pwm_out), 0);
    chk("midrst_tick", int'(sample_tick), 0);
    chk("midrst_duty", int'(duty_dbg), 128);
    pwm_value = 16'sh0000;
    Reset = 1'b0;
    step();
    wait_tick(n, h);
    chk("midrst_tick_delay", n, 255);
    chk("midrst_period_highs", h, 127);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
